band_envelope_gen: RTL and testbench

BAND_ENVELOPE_GEN -- requirements
Module: band_envelope_gen

---
 rtl/env_gen_pkg.sv | 9 +
 rtl/lfsr32_galois.sv | 14 +
 rtl/band_envelope_gen.sv | 117 +++++++++++
 tb/tb_band_envelope_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/env_gen_pkg.sv
// env_gen_pkg: shared constants, FSM state and band index types for the band envelope generator
package env_gen_pkg;
    localparam int ENV_UNITY = 16384;
    localparam int ENV_MIN = 8192;
    localparam int ENV_MAX = 24576;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, DONE} env_state_t;
    typedef logic [1:0] band_t;
endpackage

// File: rtl/lfsr32_galois.sv
// lfsr32_galois: 32-bit right-shifting Galois LFSR (x^32+x^22+x^2+x+1), zero seed mapped to 1
module lfsr32_galois (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] state
);
    import env_gen_pkg::*;
    // one Galois step per advance; an all-zero seed would lock up, so it becomes 1
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= (seed == '0) ? 32'd1 : seed;
        else if (advance) state <= (state >> 1) ^ (state[0] ? LFSR_MASK : '0);
endmodule

// File: rtl/band_envelope_gen.sv
// band_envelope_gen: four-band random slow envelope generator (optional ENV_GEN_COUPLED_EN: beta target mirrors alpha about unity)
module band_envelope_gen #(
    parameter int          WIDTH      = 18,
    parameter int          FRAC       = 14,
    parameter int          UPDATE_DIV = 100,
    parameter int          HOLD_MIN   = 80,
    parameter int          HOLD_MASK  = 127,
    parameter int          SLEW_SHIFT = 5,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    enable,
    output logic signed [WIDTH-1:0] env_theta,
    output logic signed [WIDTH-1:0] env_alpha,
    output logic signed [WIDTH-1:0] env_beta,
    output logic signed [WIDTH-1:0] env_gamma,
    output logic                    env_valid
);
    import env_gen_pkg::*;
    localparam int PW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int HW = 16;
    localparam logic signed [WIDTH-1:0] UNITY = WIDTH'(ENV_UNITY);
    localparam logic signed [WIDTH:0] LO = (WIDTH+1)'(ENV_MIN);
    localparam logic signed [WIDTH:0] HI = (WIDTH+1)'(ENV_MAX);

    env_state_t state, state_nx;
    logic [PW-1:0] presc;
    logic req, pending, leave, band_st, draw;
    logic [31:0] lfsr;
    band_t b;
    logic signed [WIDTH-1:0] env [4];
    logic signed [WIDTH-1:0] tgt [4];
    logic [HW-1:0] hold [4];
    logic signed [WIDTH-1:0] drawn, eff, nxt;
    logic signed [WIDTH:0] cur_x, eff_x, diff, sum;
    logic [HW-1:0] reload;
    logic unused_lfsr;

    assign req = clk_en && presc == PW'(UPDATE_DIV - 1);
    assign leave = state == IDLE && (req || pending);
    assign band_st = state == B0 || state == B1 || state == B2 || state == B3;
    assign b = state == B1 ? 2'd1 : state == B2 ? 2'd2 : state == B3 ? 2'd3 : 2'd0;
    assign unused_lfsr = ^{lfsr[31:30], lfsr[21:FRAC]};

    lfsr32_galois u_lfsr (
        .clk(clk),
        .rst(rst),
        .advance(band_st),
        .seed(LFSR_SEED),
        .state(lfsr)
    );

    // prescaler: count clk_en pulses and wrap on the update request
    always_ff @(posedge clk or posedge rst)
        if (rst) presc <= '0;
        else if (clk_en) presc <= req ? '0 : presc + PW'(1);

    // pending flag: remember one request that arrives mid-sequence; a request in the same clk as the clear wins
    always_ff @(posedge clk or posedge rst)
        if (rst) pending <= 1'b0;
        else pending <= (req && (state != IDLE || pending)) ? 1'b1 : leave ? 1'b0 : pending;

    // FSM state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // FSM next state: one band per clk once a sequence starts
    always_comb
        state_nx = state == IDLE ? (leave ? B0 : IDLE) :
                   state == B0 ? B1 : state == B1 ? B2 : state == B2 ? B3 :
                   state == B3 ? DONE : IDLE;

    // FSM outputs
    always_comb begin
        env_valid = state == DONE;
        env_theta = env[0];
        env_alpha = env[1];
        env_beta = env[2];
        env_gamma = env[3];
    end

    // shared datapath: target draw, hold reload, slew toward effective target and clamp
    always_comb begin
        draw = enable && hold[b] == '0;
`ifdef ENV_GEN_COUPLED_EN
        drawn = (b == 2'd2) ? WIDTH'(2 * ENV_UNITY) - tgt[1] : WIDTH'(ENV_MIN) + WIDTH'(lfsr[FRAC-1:0]);
`else
        drawn = WIDTH'(ENV_MIN) + WIDTH'(lfsr[FRAC-1:0]);
`endif
        eff = !enable ? UNITY : draw ? drawn : tgt[b];
        cur_x = env[b];
        eff_x = eff;
        diff = eff_x - cur_x;
        sum = cur_x + (diff >>> SLEW_SHIFT);
        nxt = sum < LO ? WIDTH'(LO) : sum > HI ? WIDTH'(HI) : WIDTH'(sum);
        reload = HW'(HOLD_MIN) + HW'(lfsr[29:22] & 8'(HOLD_MASK));
    end

    // per-band registers: only the band being visited changes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                env[i] <= UNITY;
                tgt[i] <= UNITY;
                hold[i] <= '0;
            end
        end else if (band_st) begin
            env[b] <= nxt;
            if (draw) begin
                tgt[b] <= drawn;
                hold[b] <= reload;
            end else if (enable) hold[b] <= hold[b] - HW'(1);
        end
endmodule

// File: tb/tb_band_envelope_gen.sv
// tb_band_envelope_gen: scoreboard bench for band_envelope_gen (honours ENV_GEN_COUPLED_EN)
module tb_band_envelope_gen;
    localparam int HMIN = 3;
    localparam int HMASK = 7;

    typedef struct {
        int e0, e1, e2, e3;
        bit en;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    logic enable = 1'b0;
    logic signed [17:0] env_theta, env_alpha, env_beta, env_gamma;
    logic env_valid;

    item_t q[$];
    logic [31:0] m_lfsr;
    int m_env[4], m_tgt[4], m_hold[4];
    int prev[4];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, vcount = 0, last_vcyc = 0;
    bit gap_on = 0, have_last = 0;

    band_envelope_gen #(
        .UPDATE_DIV(2),
        .HOLD_MIN(HMIN),
        .HOLD_MASK(HMASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .enable(enable),
        .env_theta(env_theta),
        .env_alpha(env_alpha),
        .env_beta(env_beta),
        .env_gamma(env_gamma),
        .env_valid(env_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
    endtask

    function automatic void m_reset();
        m_lfsr = 32'hACE1_2024;
        for (int n = 0; n < 4; n++) begin
            m_env[n] = 16384;
            m_tgt[n] = 16384;
            m_hold[n] = 0;
        end
    endfunction

    // reference model of one complete four-band sequence; pushes the expected envelopes
    function automatic void m_seq(bit en);
        item_t it;
        int t, d, v;
        for (int n = 0; n < 4; n++) begin
            t = m_tgt[n];
            if (!en) t = 16384;
            else if (m_hold[n] == 0) begin
`ifdef ENV_GEN_COUPLED_EN
                t = (n == 2) ? 32768 - m_tgt[1] : 8192 + int'(m_lfsr[13:0]);
`else
                t = 8192 + int'(m_lfsr[13:0]);
`endif
                m_tgt[n] = t;
                m_hold[n] = HMIN + (int'(m_lfsr[29:22]) & HMASK);
            end else m_hold[n]--;
            d = t - m_env[n];
            v = m_env[n] + (d >>> 5);
            m_env[n] = v < 8192 ? 8192 : v > 24576 ? 24576 : v;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
        end
        it.e0 = m_env[0];
        it.e1 = m_env[1];
        it.e2 = m_env[2];
        it.e3 = m_env[3];
        it.en = en;
        q.push_back(it);
    endfunction

    // monitor: pop and compare at each env_valid, check bounds, unity approach and pulse spacing
    initial forever begin
        item_t it;
        int got[4];
        @(negedge clk);
        if (rst) begin
            for (int n = 0; n < 4; n++) prev[n] = 16384;
        end else if (env_valid) begin
            vcount++;
            if (gap_on && have_last) chk("valid_gap", cyc - last_vcyc, 6);
            have_last = 1;
            last_vcyc = cyc;
            got[0] = env_theta;
            got[1] = env_alpha;
            got[2] = env_beta;
            got[3] = env_gamma;
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                it = q.pop_front();
                chk("env_theta", got[0], it.e0);
                chk("env_alpha", got[1], it.e1);
                chk("env_beta", got[2], it.e2);
                chk("env_gamma", got[3], it.e3);
                if (!it.en)
                    for (int n = 0; n < 4; n++)
                        chk("unity_approach", (prev[n] >= 16384) ? (got[n] >= 16384 && got[n] <= prev[n])
                                                                 : (got[n] <= 16384 && got[n] >= prev[n]), 1);
            end
            for (int n = 0; n < 4; n++) begin
                chk("env_range", got[n] >= 8192 && got[n] <= 24576 && got[n] != 0, 1);
                prev[n] = got[n];
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic wait_valid(input int target, input int budget);
        for (int i = 0; i < budget && vcount < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (vcount < target) chk("valid_timeout", vcount, target);
    endtask

    task automatic do_reset();
        clk_en = 1'b0;
        rst = 1'b1;
        q.delete();
        m_reset();
        @(negedge clk);
        #1;
        chk("rst_theta", env_theta, 16384);
        chk("rst_alpha", env_alpha, 16384);
        chk("rst_beta", env_beta, 16384);
        chk("rst_gamma", env_gamma, 16384);
        chk("rst_valid", env_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // two clk_en pulses make one update request with UPDATE_DIV=2
    task automatic do_seq(input bit en, input bit lat);
        int c0;
        m_seq(en);
        @(negedge clk);
        enable = en;
        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        clk_en = 1'b0;
        wait_drain(20);
        if (lat) chk("valid_latency", last_vcyc - c0 + 1, 5);
    endtask

    // clk_en held high: sequences chain through the pending flag, one extra after clk_en drops
    task automatic run_cont(input int k, input int pct);
        bit ens[$];
        int seen;
        for (int i = 0; i <= k; i++) begin
            ens.push_back($urandom_range(99) < pct);
            m_seq(ens[i]);
        end
        have_last = 0;
        gap_on = 1;
        seen = vcount;
        @(negedge clk);
        enable = ens[0];
        clk_en = 1'b1;
        for (int i = 1; i <= k; i++) begin
            wait_valid(seen + i, 20);
            enable = ens[i];
            if (i == k) clk_en = 1'b0;
        end
        wait_drain(20);
        gap_on = 0;
    endtask

    initial begin
        m_reset();
        do_reset();
        for (int i = 0; i < 3; i++) do_seq(0, 0);
        do_reset();
        do_seq(1, 1);
        for (int i = 0; i < 5; i++) do_seq(1, 0);
        for (int i = 0; i < 6; i++) do_seq(0, 0);
        for (int i = 0; i < 4; i++) do_seq(1, 0);
        do_reset();
        run_cont(20, 100);
        do_reset();
        m_seq(1);
        @(negedge clk);
        enable = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("b2rst_theta", env_theta, 16384);
        chk("b2rst_alpha", env_alpha, 16384);
        chk("b2rst_beta", env_beta, 16384);
        chk("b2rst_gamma", env_gamma, 16384);
        chk("b2rst_valid", env_valid, 0);
        q.delete();
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("valid_in_reset", env_valid, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) do_seq(1, 0);
        do_reset();
        run_cont(2000, 80);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
